// File: rtl/fsin_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fsin_seq_if : start/done handshake and shared fmult/fadd operand bus |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface fsin_seq_if;
  logic        start;
  logic [31:0] a;
  logic [3:0]  nterms;
  logic        busy;
  logic        done;
  logic [31:0] res;
  logic        err;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic [31:0] mul_res;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic [31:0] add_res;
  logic        add_nan;
  logic        add_inf;

  modport slave (
    input  start, a, nterms, mul_res, add_res, add_nan, add_inf,
    output busy, done, res, err, mul_a, mul_b, add_a, add_b
  );

  modport master (
    output start, a, nterms, mul_res, add_res, add_nan, add_inf,
    input  busy, done, res, err, mul_a, mul_b, add_a, add_b
  );
endinterface
`default_nettype wire

// File: rtl/fsin_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fsin_seq : sin(x) by Horner's rule in x^2 over shared fmult/fadd     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module fsin_seq #(
  parameter int NTERMS_MAX = 10
) (
  input  logic       clk,
  input  logic       reset,
  fsin_seq_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SQR  = 3'd1,
    S_MUL  = 3'd2,
    S_ADD  = 3'd3,
    S_FIN  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t      r_state;
  logic [31:0] r_a;
  logic [31:0] r_x2;
  logic [31:0] r_acc;
  logic [31:0] r_t;
  logic [3:0]  r_k;
  logic [3:0]  r_n;
  logic [31:0] r_res;
  logic        r_busy;
  logic        r_done;
  logic        r_err;
  logic [3:0]  w_nclamp;
  logic [3:0]  w_cidx;
  logic [31:0] w_coef;

  // Entry k is (-1)^k/(2k+1)!
  function automatic logic [31:0] f_coef(input logic [3:0] idx);
    case (idx)
      4'd0:    f_coef = 32'h3F800000;
      4'd1:    f_coef = 32'hBE2AAAAB;
      4'd2:    f_coef = 32'h3C088889;
      4'd3:    f_coef = 32'hB9500D01;
      4'd4:    f_coef = 32'h3638EF1D;
      4'd5:    f_coef = 32'hB2D7322B;
      4'd6:    f_coef = 32'h2F309231;
      4'd7:    f_coef = 32'hAB573F9F;
      4'd8:    f_coef = 32'h274A963C;
      4'd9:    f_coef = 32'hA317A4DA;
      default: f_coef = 32'h00000000;
    endcase
  endfunction

  always_comb begin
    if (bus.nterms == 4'd0) begin
      w_nclamp = 4'd1;
    end else if (bus.nterms > 4'(NTERMS_MAX)) begin
      w_nclamp = 4'(NTERMS_MAX);
    end else begin
      w_nclamp = bus.nterms;
    end
  end

  // SQR loads the highest coefficient; ADD walks k downward.
  assign w_cidx = (r_state == S_SQR) ? (r_n - 4'd1) : r_k;
  assign w_coef = f_coef(w_cidx);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_x2    <= '0;
      r_acc   <= '0;
      r_t     <= '0;
      r_k     <= '0;
      r_n     <= '0;
      r_res   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_a     <= bus.a;
            r_n     <= w_nclamp;
            r_err   <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_SQR;
          end
        end
        S_SQR: begin
          r_x2  <= bus.mul_res;
          r_acc <= w_coef;
          if (r_n == 4'd1) begin
            r_state <= S_FIN;
          end else begin
            r_k     <= r_n - 4'd2;
            r_state <= S_MUL;
          end
        end
        S_MUL: begin
          r_t     <= bus.mul_res;
          r_state <= S_ADD;
        end
        S_ADD: begin
          r_acc <= bus.add_res;
          if (bus.add_nan || bus.add_inf) begin
            r_err <= 1'b1;
          end
          if (r_k == 4'd0) begin
            r_state <= S_FIN;
          end else begin
            r_k     <= r_k - 4'd1;
            r_state <= S_MUL;
          end
        end
        S_FIN: begin
          r_res   <= bus.mul_res;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Operand muxes select among registers only, so no input reaches the shared units.
  always_comb begin
    bus.mul_a = '0;
    bus.mul_b = '0;
    bus.add_a = '0;
    bus.add_b = '0;
    case (r_state)
      S_SQR: begin
        bus.mul_a = r_a;
        bus.mul_b = r_a;
      end
      S_MUL: begin
        bus.mul_a = r_acc;
        bus.mul_b = r_x2;
      end
      S_ADD: begin
        bus.add_a = r_t;
        bus.add_b = w_coef;
      end
      S_FIN: begin
        bus.mul_a = r_acc;
        bus.mul_b = r_a;
      end
      default: begin
        bus.mul_a = '0;
      end
    endcase
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.res  = r_res;
  assign bus.err  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_fsin_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fsin_seq : randomized jobs against a series-evaluation model      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_fsin_seq;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  fsin_seq_if u_if ();

  fsin_seq #(.NTERMS_MAX(10)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single precision <-> double, normals only (subnormals flush to zero).
  function automatic real s2d(input logic [31:0] b);
    logic [63:0] d;
    if (b[30:23] == 8'h00) d = {b[31], 63'b0};
    else if (b[30:23] == 8'hFF) d = {b[31], 11'h7FF, b[22:0], 29'b0};
    else d = {b[31], 11'(int'(b[30:23]) + 896), b[22:0], 29'b0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] d2s(input real r);
    logic [63:0] d;
    logic        s;
    int          e;
    logic [24:0] m;
    d = $realtobits(r);
    s = d[63];
    if (d[62:52] == 11'h7FF) return {s, 8'hFF, (d[51:0] != 0) ? 23'h400000 : 23'h0};
    e = int'(d[62:52]) - 1023 + 127;
    if (d[62:52] == 11'h000 || e <= 0) return {s, 31'b0};
    m = {2'b01, d[51:29]};
    if (d[28] && ((|d[27:0]) || m[0])) m = m + 25'd1;
    if (m[24]) begin
      m = m >> 1;
      e++;
    end
    if (e >= 255) return {s, 8'hFF, 23'h0};
    return {s, e[7:0], m[22:0]};
  endfunction

  function automatic logic [31:0] m_fmul(input logic [31:0] x, input logic [31:0] y);
    return d2s(s2d(x) * s2d(y));
  endfunction

  function automatic logic [31:0] m_fadd(input logic [31:0] x, input logic [31:0] y);
    return d2s(s2d(x) + s2d(y));
  endfunction

  always_comb begin
    u_if.mul_res = m_fmul(u_if.mul_a, u_if.mul_b);
    u_if.add_res = m_fadd(u_if.add_a, u_if.add_b);
    u_if.add_inf = (u_if.add_res[30:23] == 8'hFF) && (u_if.add_res[22:0] == 23'h0);
    u_if.add_nan = (u_if.add_res[30:23] == 8'hFF) && (u_if.add_res[22:0] != 23'h0);
  end

  logic [31:0] coef [10];
  initial begin
    coef[0] = 32'h3F800000; coef[1] = 32'hBE2AAAAB; coef[2] = 32'h3C088889;
    coef[3] = 32'hB9500D01; coef[4] = 32'h3638EF1D; coef[5] = 32'hB2D7322B;
    coef[6] = 32'h2F309231; coef[7] = 32'hAB573F9F; coef[8] = 32'h274A963C;
    coef[9] = 32'hA317A4DA;
  end

  function automatic int clamp_n(input logic [3:0] nt);
    return (nt == 0) ? 1 : ((nt > 10) ? 10 : int'(nt));
  endfunction

  // Series sum of the truncated Taylor polynomial, x * P(x^2).
  task automatic ref_sin(input logic [31:0] x, input logic [3:0] nt,
                         output logic [31:0] r, output logic e);
    logic [31:0] x2, acc;
    int          n;
    n   = clamp_n(nt);
    e   = 1'b0;
    x2  = m_fmul(x, x);
    acc = coef[n-1];
    for (int k = n - 2; k >= 0; k--) begin
      acc = m_fadd(m_fmul(acc, x2), coef[k]);
      if (acc[30:23] == 8'hFF) e = 1'b1;
    end
    r = m_fmul(acc, x);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply one job; glitch>=0 pulses start during that cycle of the job.
  task automatic run_job(input logic [31:0] av, input logic [3:0] nt, input int glitch);
    logic [31:0] er, prev;
    logic        ee;
    int          n;
    ref_sin(av, nt, er, ee);
    n    = clamp_n(nt);
    prev = u_if.res;
    @(negedge clk);
    u_if.a      = av;
    u_if.nterms = nt;
    u_if.start  = 1'b1;
    for (int cyc = 0; cyc <= 2 * n + 1; cyc++) begin
      @(negedge clk);
      u_if.start = (cyc == glitch);
      check("busy", 32'(u_if.busy), 32'(cyc < 2 * n));
      check("done", 32'(u_if.done), 32'(cyc == 2 * n));
      if (cyc == 0) begin
        check("err_clear", 32'(u_if.err), 32'd0);
        check("add_a_idle", u_if.add_a, 32'd0);
      end
      if (cyc == 2) check("mul_a_idle", u_if.mul_a, 32'd0);
      if (cyc == 2 * n - 1) check("res_hold", u_if.res, prev);
      if (cyc == 2 * n) begin
        check("res", u_if.res, er);
        check("err", 32'(u_if.err), 32'(ee));
      end
    end
    u_if.start = 1'b0;
  endtask

  function automatic int ulp_diff(input logic [31:0] x, input logic [31:0] y);
    int d;
    d = int'(x) - int'(y);
    return (d < 0) ? -d : d;
  endfunction

  initial begin
    logic [31:0] r_n10;
    int          dcnt;
    int          n;
    logic [3:0]  nt;
    logic [31:0] av;
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    u_if.start  = 1'b0;
    u_if.a      = '0;
    u_if.nterms = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(u_if.busy), 32'd0);
    check("rst_done", 32'(u_if.done), 32'd0);
    check("rst_res", u_if.res, 32'd0);
    check("rst_err", 32'(u_if.err), 32'd0);
    check("rst_mul", u_if.mul_a | u_if.mul_b, 32'd0);
    check("rst_add", u_if.add_a | u_if.add_b, 32'd0);
    reset = 1'b0;

    run_job(32'h3F800000, 4'd1, -1);
    check("n1_res", u_if.res, 32'h3F800000);
    run_job(32'h3F800000, 4'd10, -1);
    r_n10 = u_if.res;
    check("sin1_ulp", 32'(ulp_diff(u_if.res, 32'h3F576AA4) <= 2), 32'd1);
    run_job(32'h3FC90FDB, 4'd10, 5);
    check("sinpi2_ulp", 32'(ulp_diff(u_if.res, 32'h3F800000) <= 2), 32'd1);
    run_job(32'h3F800000, 4'd0, -1);
    check("n0_res", u_if.res, 32'h3F800000);
    run_job(32'h3F800000, 4'd15, 20);
    check("n15_res", u_if.res, r_n10);

    // Abort an N=10 job at cycle 7.
    @(negedge clk);
    u_if.a = 32'h3F800000; u_if.nterms = 4'd10; u_if.start = 1'b1;
    @(negedge clk);
    u_if.start = 1'b0;
    repeat (7) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_busy", 32'(u_if.busy), 32'd0);
    check("abort_res", u_if.res, 32'd0);
    check("abort_mul", u_if.mul_a | u_if.mul_b, 32'd0);
    @(negedge clk);
    u_if.start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    u_if.start = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (u_if.done || u_if.busy) dcnt++;
    end
    check("abort_quiet", 32'(dcnt), 32'd0);
    run_job(32'h3F000000, 4'd5, -1);

    run_job(32'h7F800000, 4'd4, -1);
    check("inf_err", 32'(u_if.err), 32'd1);
    run_job(32'h3E800000, 4'd3, -1);

    for (int j = 0; j < 20; j++) begin
      av = {1'($urandom), 8'($urandom_range(118, 128)), 23'($urandom)};
      nt = 4'($urandom_range(0, 15));
      n  = clamp_n(nt);
      run_job(av, nt, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2 * n)) : -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
